// File: rtl/delay_scheduler.sv
// Shares one microsecond delay timer among NUM_REQ requesters, round-robin.
// Latency: grant the edge after req is sampled; done delay_us*CLOCK_SPEED_MHZ edges later.
// Backpressure: none; requesters hold req level until done, and dropping req aborts the delay.
module delay_scheduler #(
    parameter int CLOCK_SPEED_MHZ = 12,
    parameter int NUM_REQ         = 4,
    parameter int DELAY_W         = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DELAY_W-1:0] delay_us,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic                       busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int PS_W  = $clog2(CLOCK_SPEED_MHZ);
    localparam logic [PS_W-1:0]    PS_LAST = PS_W'(CLOCK_SPEED_MHZ - 1);
    localparam logic [NUM_REQ-1:0] BIT0    = NUM_REQ'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     winner;
    logic [IDX_W-1:0]     rr_ptr;
    logic [PS_W-1:0]      prescaler;
    logic [DELAY_W-1:0]   remaining;

    logic                 win_vld;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     cand;
    logic [DELAY_W-1:0]   win_delay;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = (int'(base) + off) % NUM_REQ;
        return IDX_W'(sum);
    endfunction

    // Scan downward so the candidate closest to rr_ptr is the last one to land.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = wrap_add(rr_ptr, k);
            if (req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign win_delay = delay_us[win_idx*DELAY_W +: DELAY_W];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            winner    <= '0;
            rr_ptr    <= '0;
            prescaler <= '0;
            remaining <= '0;
            grant     <= '0;
            done      <= '0;
            busy      <= 1'b0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        winner    <= win_idx;
                        remaining <= win_delay;
                        prescaler <= '0;
                        busy      <= 1'b1;
                        if (win_delay != '0) begin
                            grant <= BIT0 << win_idx;
                            state <= RUN;
                        end else begin
                            // Zero delay skips the timer entirely; grant never rises.
                            done  <= BIT0 << win_idx;
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (!req[winner]) begin
                        // Owner withdrew: release silently, abort wins over any tick.
                        state  <= IDLE;
                        grant  <= '0;
                        busy   <= 1'b0;
                        rr_ptr <= wrap_add(winner, 1);
                    end else if (prescaler == PS_LAST) begin
                        prescaler <= '0;
                        remaining <= remaining - DELAY_W'(1);
                        if (remaining == DELAY_W'(1)) begin
                            state <= DONE;
                            grant <= '0;
                            done  <= BIT0 << winner;
                        end
                    end else begin
                        prescaler <= prescaler + PS_W'(1);
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    rr_ptr <= wrap_add(winner, 1);
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_scheduler.sv
// Self-checking bench for delay_scheduler: directed scenarios plus randomized traffic
// compared cycle by cycle against a transaction-level timeline model.
module tb_delay_scheduler;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  req_a = '0;
    logic [63:0] dly_a = '0;
    logic [3:0]  grant_a, done_a;
    logic        busy_a;
    logic [3:0]  req_b = '0;
    logic [15:0] dly_b = '0;
    logic [3:0]  grant_b, done_b;
    logic        busy_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    delay_scheduler #(.CLOCK_SPEED_MHZ(4), .NUM_REQ(4), .DELAY_W(16)) dut_a (
        .CLK(CLK), .RST(RST), .req(req_a), .delay_us(dly_a),
        .grant(grant_a), .done(done_a), .busy(busy_a)
    );

    delay_scheduler #(.CLOCK_SPEED_MHZ(2), .NUM_REQ(4), .DELAY_W(4)) dut_b (
        .CLK(CLK), .RST(RST), .req(req_b), .delay_us(dly_b),
        .grant(grant_b), .done(done_b), .busy(busy_b)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (n_fail=%0d)", n_fail);
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge CLK);
        RST   = 1'b1;
        req_a = '0;
        req_b = '0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks += 6;
        if (grant_a !== 4'b0) begin n_fail++; $display("FAIL reset grant_a got %b want 0000", grant_a); end
        if (done_a  !== 4'b0) begin n_fail++; $display("FAIL reset done_a got %b want 0000", done_a); end
        if (busy_a  !== 1'b0) begin n_fail++; $display("FAIL reset busy_a got %b want 0", busy_a); end
        if (grant_b !== 4'b0) begin n_fail++; $display("FAIL reset grant_b got %b want 0000", grant_b); end
        if (done_b  !== 4'b0) begin n_fail++; $display("FAIL reset done_b got %b want 0000", done_b); end
        if (busy_b  !== 1'b0) begin n_fail++; $display("FAIL reset busy_b got %b want 0", busy_b); end
    endtask

    // delay 3 at 4 MHz: 12 grant cycles, done at cycle 12, busy for 13 cycles
    task automatic test_single();
        logic [3:0] eg, ed;
        do_reset();
        dly_a[0 +: 16] = 16'd3;
        req_a = 4'b0001;
        for (int t = 0; t < 18; t++) begin
            @(negedge CLK);
            eg = (t < 12) ? 4'b0001 : 4'b0000;
            ed = (t == 12) ? 4'b0001 : 4'b0000;
            n_checks += 3;
            if (grant_a !== eg) begin n_fail++; $display("FAIL single grant t=%0d got %b want %b", t, grant_a, eg); end
            if (done_a !== ed) begin n_fail++; $display("FAIL single done t=%0d got %b want %b", t, done_a, ed); end
            if (busy_a !== (t <= 12)) begin n_fail++; $display("FAIL single busy t=%0d got %b want %b", t, busy_a, (t <= 12)); end
            if (done_a[0]) req_a[0] = 1'b0;
        end
    endtask

    // all four requesting with delay 1: 4 grant + 1 done + 1 idle per slot, order 0,1,2,3,0
    task automatic test_round_robin();
        logic [3:0] eg, ed;
        int k, ph;
        do_reset();
        for (int i = 0; i < 4; i++) dly_a[i*16 +: 16] = 16'd1;
        req_a = 4'b1111;
        for (int t = 0; t < 30; t++) begin
            @(negedge CLK);
            k  = t / 6;
            ph = t % 6;
            eg = (ph < 4)  ? (4'b0001 << (k % 4)) : 4'b0000;
            ed = (ph == 4) ? (4'b0001 << (k % 4)) : 4'b0000;
            n_checks += 2;
            if (grant_a !== eg) begin n_fail++; $display("FAIL rr grant t=%0d got %b want %b", t, grant_a, eg); end
            if (done_a !== ed) begin n_fail++; $display("FAIL rr done t=%0d got %b want %b", t, done_a, ed); end
        end
        req_a = '0;
    endtask

    task automatic test_zero_delay();
        do_reset();
        dly_a[2*16 +: 16] = 16'd0;
        req_a = 4'b0100;
        @(negedge CLK);
        n_checks += 3;
        if (grant_a !== 4'b0000) begin n_fail++; $display("FAIL zero grant got %b want 0000", grant_a); end
        if (done_a !== 4'b0100) begin n_fail++; $display("FAIL zero done got %b want 0100", done_a); end
        if (busy_a !== 1'b1) begin n_fail++; $display("FAIL zero busy got %b want 1", busy_a); end
        req_a = 4'b0000;
        @(negedge CLK);
        n_checks += 2;
        if (done_a !== 4'b0000) begin n_fail++; $display("FAIL zero done_clear got %b want 0000", done_a); end
        if (busy_a !== 1'b0) begin n_fail++; $display("FAIL zero idle busy got %b want 0", busy_a); end
        for (int i = 0; i < 4; i++) dly_a[i*16 +: 16] = 16'd1;
        req_a = 4'b1101;
        @(negedge CLK);
        n_checks++;
        if (grant_a !== 4'b1000) begin n_fail++; $display("FAIL zero rr_ptr grant got %b want 1000", grant_a); end
        req_a = '0;
    endtask

    task automatic test_abort();
        do_reset();
        dly_a[1*16 +: 16] = 16'd5;
        dly_a[0*16 +: 16] = 16'd2;
        req_a = 4'b0010;
        for (int t = 0; t < 9; t++) begin
            @(negedge CLK);
            n_checks++;
            if (done_a !== 4'b0000) begin n_fail++; $display("FAIL abort done t=%0d got %b want 0000", t, done_a); end
            if (t <= 6) begin
                n_checks++;
                if (grant_a !== 4'b0010) begin n_fail++; $display("FAIL abort grant1 t=%0d got %b want 0010", t, grant_a); end
            end else if (t == 7) begin
                n_checks += 2;
                if (grant_a !== 4'b0000) begin n_fail++; $display("FAIL abort release got %b want 0000", grant_a); end
                if (busy_a !== 1'b0) begin n_fail++; $display("FAIL abort busy got %b want 0", busy_a); end
            end else begin
                n_checks++;
                if (grant_a !== 4'b0001) begin n_fail++; $display("FAIL abort next grant got %b want 0001", grant_a); end
            end
            if (t == 0) req_a[0] = 1'b1;
            if (t == 6) req_a[1] = 1'b0;
        end
        req_a = '0;
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        dly_a[2*16 +: 16] = 16'd4;
        dly_a[1*16 +: 16] = 16'd1;
        req_a = 4'b0100;
        for (int t = 0; t < 3; t++) begin
            @(negedge CLK);
            n_checks++;
            if (grant_a !== 4'b0100) begin n_fail++; $display("FAIL rstrun grant t=%0d got %b want 0100", t, grant_a); end
        end
        RST = 1'b1;
        @(negedge CLK);
        n_checks += 3;
        if (grant_a !== 4'b0000) begin n_fail++; $display("FAIL rstrun grant got %b want 0000", grant_a); end
        if (done_a !== 4'b0000) begin n_fail++; $display("FAIL rstrun done got %b want 0000", done_a); end
        if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rstrun busy got %b want 0", busy_a); end
        RST   = 1'b0;
        req_a = 4'b0110;
        @(negedge CLK);
        n_checks += 2;
        if (grant_a !== 4'b0010) begin n_fail++; $display("FAIL rstrun first grant got %b want 0010", grant_a); end
        if (done_a !== 4'b0000) begin n_fail++; $display("FAIL rstrun stray done got %b want 0000", done_a); end
        req_a = '0;
    endtask

    // 4-bit delay field at full scale, 2 MHz: 30 grant cycles, done once, no wrap
    task automatic test_max_value();
        logic [3:0] eg, ed;
        do_reset();
        dly_b[0 +: 4] = 4'd15;
        req_b = 4'b0001;
        for (int t = 0; t < 36; t++) begin
            @(negedge CLK);
            eg = (t < 30) ? 4'b0001 : 4'b0000;
            ed = (t == 30) ? 4'b0001 : 4'b0000;
            n_checks += 3;
            if (grant_b !== eg) begin n_fail++; $display("FAIL max grant t=%0d got %b want %b", t, grant_b, eg); end
            if (done_b !== ed) begin n_fail++; $display("FAIL max done t=%0d got %b want %b", t, done_b, ed); end
            if (busy_b !== (t <= 30)) begin n_fail++; $display("FAIL max busy t=%0d got %b want %b", t, busy_b, (t <= 30)); end
            if (done_b[0]) req_b[0] = 1'b0;
        end
    endtask

    // Random held-high request sets with random per-service delays. The model lays out the
    // timeline as slots: d*4 grant cycles, one done cycle, one idle cycle, next winner round-robin.
    task automatic test_random();
        int unsigned dtab[4][16];
        int          mcnt[4];
        int          rcnt[4];
        logic [8:0]  expq[$];
        logic [8:0]  exp_v, got_v;
        logic [3:0]  pat;
        int          ptr, w, d;
        for (int r = 0; r < 4; r++) begin
            do_reset();
            pat = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 16; j++) dtab[i][j] = $urandom_range(0, 3);
                mcnt[i] = 0;
                rcnt[i] = 0;
                dly_a[i*16 +: 16] = 16'(dtab[i][0]);
            end
            expq.delete();
            ptr = 0;
            for (int tx = 0; tx < 10; tx++) begin
                w = -1;
                for (int k = 3; k >= 0; k--)
                    if (pat[(ptr + k) % 4]) w = (ptr + k) % 4;
                d = int'(dtab[w][mcnt[w]]);
                mcnt[w]++;
                for (int c = 0; c < d * 4; c++) expq.push_back({4'b0001 << w, 4'b0000, 1'b1});
                expq.push_back({4'b0000, 4'b0001 << w, 1'b1});
                expq.push_back(9'b0);
                ptr = (w + 1) % 4;
            end
            req_a = pat;
            for (int t = 0; t < expq.size(); t++) begin
                @(negedge CLK);
                exp_v = expq[t];
                got_v = {grant_a, done_a, busy_a};
                n_checks += 3;
                if (got_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL random r=%0d t=%0d {grant,done,busy} got %b want %b", r, t, got_v, exp_v);
                end
                if (!$onehot0(grant_a) || !$onehot0(done_a)) begin
                    n_fail++;
                    $display("FAIL random onehot r=%0d t=%0d grant %b done %b want one-hot or zero", r, t, grant_a, done_a);
                end
                if ((grant_a & done_a) !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL random overlap r=%0d t=%0d grant&done got %b want 0000", r, t, grant_a & done_a);
                end
                for (int i = 0; i < 4; i++) begin
                    if (done_a[i] && rcnt[i] < 15) begin
                        rcnt[i]++;
                        dly_a[i*16 +: 16] = 16'(dtab[i][rcnt[i]]);
                    end
                end
            end
            req_a = '0;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_zero_delay();
        test_abort();
        test_reset_mid_run();
        test_max_value();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
